frac_n_div_ctrl: RTL and testbench

Sequencing controller for the fractional-N feedback divider. It owns the integer/fractional frequency word and drives the second-order sigma-delta modulator's fractional input. Once per division period it steps the modulator and builds the next modulus as integer + modulator bit. Config updates are accepted through a valid/ready handshake and applied only on a division boundary, so the modulus never glitches mid-period.

---
 rtl/frac_n_pkg.sv | 25 ++
 rtl/frac_n_mod_counter.sv | 39 +++
 rtl/frac_n_div_ctrl.sv | 160 ++++++++++++++++
 tb/tb_frac_n_div_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/frac_n_pkg.sv
// Shared types, defaults and helpers for the fractional-N divider controller.
package frac_n_pkg;

  localparam int DEF_N_W     = 8;
  localparam int DEF_F_W     = 10;
  localparam int DEF_MIN_INT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  function automatic logic [DEF_N_W-1:0] clamp_int(
    input logic [DEF_N_W-1:0] v,
    input logic [DEF_N_W-1:0] min_v
  );
    if (v < min_v) begin
      return min_v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/frac_n_mod_counter.sv
// Loadable down-counter for one division period; tc flags the last cycle.
module frac_n_mod_counter #(
  parameter int C_W = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           load,
  input  logic [C_W-1:0] load_val,
  output logic           tc
);

  logic [C_W-1:0] count_q;
  logic [C_W-1:0] count_d;

  // Load wins over counting; the counter parks at zero while disabled.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != {C_W{1'b0}})) begin
      count_d = count_q - C_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  assign tc = en && (count_q == {C_W{1'b0}});

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {C_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frac_n_div_ctrl.sv
// Fractional-N feedback divider sequencer: owns the frequency word, steps the
// sigma-delta modulator once per period and swaps config only on boundaries.
module frac_n_div_ctrl
  import frac_n_pkg::*;
#(
  parameter int N_W     = DEF_N_W,
  parameter int F_W     = DEF_F_W,
  parameter int MIN_INT = DEF_MIN_INT
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           enable,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [N_W-1:0] cfg_int,
  input  logic [F_W-1:0] cfg_frac,
  output logic [F_W-1:0] sdm_alpha,
  output logic           sdm_step,
  input  logic           sdm_out,
  output logic           div_pulse,
  output logic [N_W:0]   cur_mod,
  output logic           running
);

  localparam int C_W = N_W + 1;

  state_e         state_q, state_d;
  logic [N_W-1:0] active_int_q, active_int_d;
  logic [F_W-1:0] active_frac_q, active_frac_d;
  logic [N_W-1:0] shadow_int_q, shadow_int_d;
  logic [F_W-1:0] shadow_frac_q, shadow_frac_d;
  logic           pending_q, pending_d;
  logic [C_W-1:0] cur_mod_q, cur_mod_d;
  logic           div_pulse_q, div_pulse_d;
  logic           sdm_step_q, sdm_step_d;
  logic           running_q, running_d;

  logic           tc;
  logic           xfer;
  logic           start;
  logic           reload;
  logic           mod_bit;
  logic [C_W-1:0] next_mod;
  logic [C_W-1:0] cnt_load_val;
  logic [N_W-1:0] int_clamped;

  assign int_clamped = clamp_int(cfg_int, N_W'(MIN_INT));

  // In STOP a re-raised enable turns the boundary back into a normal reload.
  always_comb begin
    xfer         = cfg_valid && !pending_q;
    start        = (state_q == ST_IDLE) && enable;
    reload       = tc && ((state_q == ST_RUN) || enable);
    mod_bit      = (active_frac_q != {F_W{1'b0}}) ? sdm_out : 1'b0;
    next_mod     = {1'b0, active_int_q} + {{N_W{1'b0}}, mod_bit};
    cnt_load_val = start ? ({1'b0, active_int_q} - C_W'(1)) : (next_mod - C_W'(1));
  end

  // Next-state for the FSM, frequency-word registers and registered outputs.
  always_comb begin
    state_d       = state_q;
    active_int_d  = active_int_q;
    active_frac_d = active_frac_q;
    shadow_int_d  = shadow_int_q;
    shadow_frac_d = shadow_frac_q;
    pending_d     = pending_q;
    cur_mod_d     = cur_mod_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (enable) state_d = ST_RUN;
        else        state_d = ST_STOP;
      end
      ST_STOP: begin
        if (enable)  state_d = ST_RUN;
        else if (tc) state_d = ST_IDLE;
        else         state_d = ST_STOP;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      cur_mod_d = {1'b0, active_int_q};
    end else if (reload) begin
      cur_mod_d = next_mod;
    end else begin
      cur_mod_d = cur_mod_q;
    end

    // A held word is applied only at a boundary; xfer cannot coincide with it.
    if (tc && pending_q) begin
      active_int_d  = shadow_int_q;
      active_frac_d = shadow_frac_q;
      pending_d     = 1'b0;
    end else if (xfer) begin
      if (state_q == ST_IDLE) begin
        active_int_d  = int_clamped;
        active_frac_d = cfg_frac;
      end else begin
        shadow_int_d  = int_clamped;
        shadow_frac_d = cfg_frac;
        pending_d     = 1'b1;
      end
    end else begin
      pending_d = pending_q;
    end

    div_pulse_d = tc;
    sdm_step_d  = tc;
    running_d   = (state_d != ST_IDLE);
  end

  frac_n_mod_counter #(.C_W(C_W)) u_counter (
    .clk      (CLK),
    .rst      (RST),
    .en       (state_q != ST_IDLE),
    .load     (start || reload),
    .load_val (cnt_load_val),
    .tc       (tc)
  );

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      active_int_q  <= {N_W{1'b0}};
      active_frac_q <= {F_W{1'b0}};
      shadow_int_q  <= {N_W{1'b0}};
      shadow_frac_q <= {F_W{1'b0}};
      pending_q     <= 1'b0;
      cur_mod_q     <= {C_W{1'b0}};
      div_pulse_q   <= 1'b0;
      sdm_step_q    <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_int_q  <= active_int_d;
      active_frac_q <= active_frac_d;
      shadow_int_q  <= shadow_int_d;
      shadow_frac_q <= shadow_frac_d;
      pending_q     <= pending_d;
      cur_mod_q     <= cur_mod_d;
      div_pulse_q   <= div_pulse_d;
      sdm_step_q    <= sdm_step_d;
      running_q     <= running_d;
    end
  end

  assign cfg_ready = !pending_q;
  assign sdm_alpha = active_frac_q;
  assign sdm_step  = sdm_step_q;
  assign div_pulse = div_pulse_q;
  assign cur_mod   = cur_mod_q;
  assign running   = running_q;

endmodule

// File: tb/tb_frac_n_div_ctrl.sv
// Randomized bench for frac_n_div_ctrl against a period-level reference model
// that tracks absolute boundary times rather than a down-counter.
module tb_frac_n_div_ctrl;

  localparam int N_W = 8;
  localparam int F_W = 10;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           enable = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [N_W-1:0] cfg_int = '0;
  logic [F_W-1:0] cfg_frac = '0;
  logic [F_W-1:0] sdm_alpha;
  logic           sdm_step;
  logic           sdm_out = 1'b0;
  logic           div_pulse;
  logic [N_W:0]   cur_mod;
  logic           running;

  int checks = 0;
  int errors = 0;

  // reference model: mode, time of next boundary, live and held words
  int m_state, m_bound, m_mod, m_ai, m_af, m_si, m_sf;
  bit m_pend, exp_pulse;
  int n = 0;
  int last_n, last_mod;
  bit last_valid;
  int sdm_mode = 0;

  frac_n_div_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_int   (cfg_int),
    .cfg_frac  (cfg_frac),
    .sdm_alpha (sdm_alpha),
    .sdm_step  (sdm_step),
    .sdm_out   (sdm_out),
    .div_pulse (div_pulse),
    .cur_mod   (cur_mod),
    .running   (running)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_bound = 0; m_mod = 0;
    m_ai = 0; m_af = 0; m_si = 0; m_sf = 0;
    m_pend = 1'b0; exp_pulse = 1'b0; last_valid = 1'b0;
  endtask

  // One clock edge of the behavioural model; n is the index of this edge.
  task automatic model_step();
    int  old_state, nm, word;
    bit  tc, xfer;
    old_state = m_state;
    tc   = (m_state != M_IDLE) && (n == m_bound);
    xfer = cfg_valid && !m_pend;
    word = (int'(cfg_int) < 2) ? 2 : int'(cfg_int);
    exp_pulse = tc;
    if (old_state == M_IDLE) begin
      if (enable) begin
        m_state = M_RUN; m_mod = m_ai; m_bound = n + m_ai; last_valid = 1'b0;
      end
      if (xfer) begin m_ai = word; m_af = int'(cfg_frac); end
    end else begin
      if (tc) begin
        if (old_state == M_RUN || enable) begin
          nm = m_ai + ((m_af != 0 && sdm_out) ? 1 : 0);
          m_mod = nm; m_bound = n + nm;
        end
        if (m_pend) begin m_ai = m_si; m_af = m_sf; m_pend = 1'b0; end
      end
      if (xfer) begin m_si = word; m_sf = int'(cfg_frac); m_pend = 1'b1; end
      if (enable)                  m_state = M_RUN;
      else if (old_state == M_RUN) m_state = M_STOP;
      else if (tc)                 m_state = M_IDLE;
      else                         m_state = M_STOP;
    end
  endtask

  task automatic compare_all();
    chk("div_pulse", div_pulse, exp_pulse);
    chk("sdm_step", sdm_step, exp_pulse);
    chk("cur_mod", cur_mod, m_mod);
    chk("running", running, m_state != M_IDLE);
    chk("cfg_ready", cfg_ready, !m_pend);
    chk("sdm_alpha", sdm_alpha, m_af);
    // pulse spacing must equal the modulus announced with the previous pulse
    if (div_pulse) begin
      if (last_valid) chk("period", n - last_n, last_mod);
      last_valid = 1'b1; last_n = n; last_mod = m_mod;
    end else if (m_state == M_IDLE) begin
      last_valid = 1'b0;
    end
  endtask

  task automatic step();
    if (sdm_mode == 0)      sdm_out = 1'b0;
    else if (sdm_mode == 1) sdm_out = 1'b1;
    else if (sdm_mode == 3) sdm_out = 1'($urandom_range(0, 1));
    else                    sdm_out = sdm_out;
    @(posedge CLK);
    n++;
    if (RST) model_reset();
    else     model_step();
    #1;
    compare_all();
    if (sdm_mode == 2 && exp_pulse) sdm_out = !sdm_out;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic cfg_word(input int i, input int f);
    cfg_int = N_W'(i); cfg_frac = F_W'(f); cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 compare_all();
    run(2);
    RST = 1'b0;
    run(2);

    // integer-only division
    cfg_word(5, 0); enable = 1'b1; sdm_mode = 3; run(30);
    enable = 1'b0; run(12);

    // fractional: constant carry, then alternating carry
    sdm_mode = 1; cfg_word(5, 256); enable = 1'b1; run(30);
    sdm_out = 1'b1; sdm_mode = 2; run(30);

    // reconfigure while running, with a second offer that must stall
    sdm_mode = 0;
    for (int i = 0; i < 20 && (m_bound - n) != 4; i++) step();
    cfg_int = 8'd7; cfg_frac = '0; cfg_valid = 1'b1; step();
    cfg_int = 8'd9; run(3);
    cfg_valid = 1'b0; run(30);

    // stop mid-period, restart, and re-raise enable while draining
    run(3); enable = 1'b0; run(15);
    enable = 1'b1; run(20);
    enable = 1'b0; run(2); enable = 1'b1; run(20);
    enable = 1'b0; run(15);

    // clamped integer words
    cfg_word(1, 0); enable = 1'b1; run(12);
    enable = 1'b0; run(15);
    cfg_word(0, 0); enable = 1'b1; run(10);
    enable = 1'b0; run(6);

    // random soak
    sdm_mode = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) enable = !enable;
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_int   = N_W'($urandom_range(0, 12));
      cfg_frac  = ($urandom_range(0, 3) == 0) ? '0 : F_W'($urandom);
      step();
    end
    cfg_valid = 1'b0;

    // asynchronous reset mid-period with a held word
    enable = 1'b1; run(5);
    for (int i = 0; i < 20 && m_pend; i++) step();
    cfg_word(11, 0); run(1);
    RST = 1'b1;
    #1;
    model_reset();
    compare_all();
    step();
    RST = 1'b0; enable = 1'b0;
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
